pool_feature_serializer: RTL
============================

# pool_feature_serializer

Downstream stage of the max-pool output in the conv study pipeline. It accepts one 6-channel vector of signed 16-bit pooled features per input strobe and buffers vectors in a small FIFO. Each element is requantized (ReLU, rounding right shift, saturation to unsigned 8-bit) and emitted as a byte stream with valid/ready handshake and channel/frame markers, one byte per accepted transfer. The block replaces direct wide-bus consumption of pooled features with a narrow, back-pressurable stream.

## Interface
- DATA_WIDTH, 16, width of each signed input feature
- NUM_CHANNELS, 6, elements per input vector
- OUT_WIDTH, 8, width of unsigned output byte
- FRAC_SHIFT, 4, right-shift applied during requantization (≥1)
- FIFO_DEPTH, 4, vector entries buffered
- FRAME_PIXELS, 196, vectors per frame (14×14)

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  input vector strobe (no backpressure upstream)
- i_features  in  NUM_CHANNELS×DATA_WIDTH signed  input vector, sampled when i_valid=1
- i_ready  in  1  downstream ready
- o_valid  out  1  o_data holds a byte
- o_data  out  OUT_WIDTH  requantized unsigned byte
- o_channel  out  $clog2(NUM_CHANNELS)  channel index of o_data
- o_last  out  1  last byte of frame (channel NUM_CHANNELS-1 of vector FRAME_PIXELS-1)
- o_overflow  out  1  sticky: an input vector was dropped

## Operation
- FIFO write on i_valid. Write accepted if count < FIFO_DEPTH, or if the head vector is popped in the same cycle. A pop occurs when the output register loads the head's final channel. Otherwise the vector is dropped and o_overflow is set; it stays set until rst.
- Requant per element x:
  - x < 0 gives 0 (ReLU).
  - Otherwise y = (x + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed in DATA_WIDTH+1 bits so the add cannot overflow.
  - o_data = min(y, 2^OUT_WIDTH − 1).
- Output FSM, two states:
  - EMPTY: o_valid=0. Go to LOADED when the FIFO is non-empty; the output register loads requant(head[chan_idx]), chan_idx, and last flag.
  - LOADED: o_valid=1. A transfer happens when o_valid && i_ready. On transfer, the register reloads the next byte in the same cycle if one is available and stays LOADED. Otherwise it goes to EMPTY.
- Counters:
  - chan_idx counts 0..NUM_CHANNELS-1 across the head vector and pops the head after the last channel is loaded.
  - pixel_cnt counts 0..FRAME_PIXELS-1 per popped vector and wraps to 0 after the vector that produces o_last.
- While o_valid=1 and i_ready=0, o_data, o_channel and o_last hold stable.
- Reset values: o_valid=0, o_data=0, o_channel=0, o_last=0, o_overflow=0. FIFO is empty and chan_idx=pixel_cnt=0.
- Reset mid-frame discards all buffered data. The next accepted vector is pixel 0.

## Timing
- Latency: with the block idle, i_valid sampled at edge N gives o_valid=1 after edge N+1, carrying channel 0.
- Throughput: 1 byte/cycle with i_ready held high. The sustained input limit is 1 vector per NUM_CHANNELS cycles; bursts up to FIFO_DEPTH vectors beyond that are absorbed.
- Back-to-back vectors stream without bubbles: channel NUM_CHANNELS-1 of vector k is followed on the next cycle by channel 0 of vector k+1.
- Simultaneous write and pop when the FIFO is full: the write is accepted, count is unchanged, and o_overflow is not set.
- rst has priority over all other inputs in the same cycle.

## Test plan
- Single vector {0x0123, −5, 0x7FFF, 0x0FF7, 0x0FF8, 0x0008} with i_ready=1:
  - o_valid rises after edge N+1.
  - Bytes 0x12, 0x00, 0xFF, 0xFF, 0xFF, 0x01 appear on 6 consecutive cycles with o_channel 0..5.
  - o_last=0 throughout.
- Backpressure: same vector with i_ready toggling 1,0,0,1,…. Each byte holds stable while i_ready=0, no byte is duplicated or skipped, and the order is unchanged.
- Overflow:
  - i_ready=0 and 5 vectors on consecutive cycles: the first 4 are buffered, the 5th is dropped, and o_overflow=1 from the following cycle.
  - Release i_ready: exactly 24 bytes out. o_overflow stays 1 until rst.
- Full plus simultaneous pop: FIFO full, i_ready=1, i_valid asserted on the cycle the head's channel-5 byte is loaded. The vector is accepted and o_overflow stays 0.
- Frame: 196 vectors of value 0x0010 at one per 6 cycles. 1176 bytes of 0x01 come out, o_last=1 only on byte 1176 (channel 5). A 197th vector restarts at pixel 0 and its channel-5 byte has o_last=0.
- Reset mid-frame: rst pulsed for 1 cycle after 50 vectors with bytes pending. All outputs read 0 the next cycle with the FIFO empty. The next frame's o_last lands on byte 1176 after reset.

Source files
------------

// File: rtl/pool_feature_serializer.sv
// Buffers 6-channel pooled feature vectors in a small FIFO and streams them out
// as requantized bytes (ReLU, rounding shift, u8 saturation) over valid/ready.
module pool_feature_serializer #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 6,
    parameter int OUT_WIDTH    = 8,
    parameter int FRAC_SHIFT   = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_PIXELS = 196
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   i_features,
    input  logic                                 i_ready,
    output logic                                 o_valid,
    output logic [OUT_WIDTH-1:0]                 o_data,
    output logic [$clog2(NUM_CHANNELS)-1:0]      o_channel,
    output logic                                 o_last,
    output logic                                 o_overflow
);

    localparam int CH_W  = $clog2(NUM_CHANNELS);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam int VEC_W = NUM_CHANNELS * DATA_WIDTH;
    localparam int SUM_W = DATA_WIDTH + 1;

    localparam logic [CH_W-1:0]      LAST_CH   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [PTR_W-1:0]     LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PIX_W-1:0]     LAST_PIX  = PIX_W'(FRAME_PIXELS - 1);
    localparam logic [SUM_W-1:0]     ROUND     = SUM_W'(2 ** (FRAC_SHIFT - 1));
    localparam logic [SUM_W-1:0]     MAX_Y     = SUM_W'(2 ** OUT_WIDTH - 1);
    localparam logic [OUT_WIDTH-1:0] MAX_OUT   = {OUT_WIDTH{1'b1}};

    localparam logic [0:0] EMPTY  = 1'b0;
    localparam logic [0:0] LOADED = 1'b1;

    logic [VEC_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CH_W-1:0]       chan_idx;
    logic [PIX_W-1:0]      pixel_cnt;
    logic [0:0]            state;

    logic [VEC_W-1:0]      head_vec;
    logic [DATA_WIDTH-1:0] head_elem;
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      shifted;
    logic [OUT_WIDTH-1:0]  req_byte;
    logic                  load, last_chan, pop, wr_en;

    assign o_valid   = (state == LOADED);
    assign head_vec  = mem[rd_ptr];
    assign last_chan = (chan_idx == LAST_CH);
    // The output register only refills when it is empty or its byte leaves this cycle.
    assign load      = (count != '0) && (!o_valid || i_ready);
    assign pop       = load && last_chan;
    assign wr_en     = i_valid && ((count != DEPTH_CNT) || pop);

    always_comb begin
        head_elem = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (chan_idx == CH_W'(c)) head_elem = head_vec[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // One extra bit of headroom keeps the rounding add from wrapping at the positive limit.
    always_comb begin
        sum     = {1'b0, head_elem} + ROUND;
        shifted = sum >> FRAC_SHIFT;
        if (head_elem[DATA_WIDTH-1])
            req_byte = '0;
        else if (shifted > MAX_Y)
            req_byte = MAX_OUT;
        else
            req_byte = shifted[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= i_features;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            o_data     <= '0;
            o_channel  <= '0;
            o_last     <= 1'b0;
            o_overflow <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            chan_idx   <= '0;
            pixel_cnt  <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);

            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (i_valid && !wr_en) o_overflow <= 1'b1;

            if (load) begin
                o_data    <= req_byte;
                o_channel <= chan_idx;
                o_last    <= last_chan && (pixel_cnt == LAST_PIX);
                chan_idx  <= last_chan ? '0 : chan_idx + CH_W'(1);
                if (last_chan) pixel_cnt <= (pixel_cnt == LAST_PIX) ? '0 : pixel_cnt + PIX_W'(1);
            end

            case (state)
                EMPTY:  if (load) state <= LOADED;
                LOADED: if (i_ready && !load) state <= EMPTY;
            endcase
        end
    end

endmodule
